// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered ALU between NREQ requesters
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [WIDTH*NREQ-1:0] REQ_A,
  input  logic [WIDTH*NREQ-1:0] REQ_B,
  input  logic [NREQ-1:0]       REQ_CIN,
  input  logic [4*NREQ-1:0]     REQ_SEL,
  output logic [NREQ-1:0]       RSP_VALID,
  output logic [WIDTH-1:0]      RSP_Y,
  output logic [WIDTH-1:0]      ALU_A,
  output logic [WIDTH-1:0]      ALU_B,
  output logic                  ALU_CIN,
  output logic [3:0]            ALU_SEL,
  input  logic [WIDTH-1:0]      ALU_Y,
  output logic                  BUSY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [2:0]       cnt;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             handshake;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr;
`endif

  // Pick the winning requester among the currently valid ones
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ_VALID[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && REQ_VALID[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
`endif
  end

  // Ready is offered only in IDLE, and never while reset is asserted so a reset cycle cannot complete a handshake
  always_comb begin
    REQ_READY = '0;
    if (state == S_IDLE && !RST && grant_found) REQ_READY = NREQ'(1) << grant_idx;
  end

  assign handshake = |(REQ_VALID & REQ_READY);
  assign BUSY      = (state != S_IDLE);

  // Control FSM: issue the granted operation, count down the ALU latency, return the result
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      owner     <= '0;
      cnt       <= '0;
      RSP_VALID <= '0;
      RSP_Y     <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_CIN   <= 1'b0;
      ALU_SEL   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (handshake) begin
            ALU_A   <= REQ_A[grant_idx*WIDTH +: WIDTH];
            ALU_B   <= REQ_B[grant_idx*WIDTH +: WIDTH];
            ALU_CIN <= REQ_CIN[grant_idx];
            ALU_SEL <= REQ_SEL[grant_idx*4 +: 4];
            owner   <= grant_idx;
            cnt     <= 3'(ALU_LAT);
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr     <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The extra WAIT cycle at cnt==0 is where the registered ALU output becomes valid
          if (cnt == 3'd0) begin
            RSP_Y     <= ALU_Y;
            RSP_VALID <= NREQ'(1) << owner;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          RSP_VALID <= '0;
          state     <= S_IDLE;
        end
        default: begin
          RSP_VALID <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
